// File: rtl/lfsr_arb_pkg.sv
// Shared types and helpers for the LFSR random-number arbiter.
// FSM state encoding, default LFSR constants and the Galois step function.
package lfsr_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        GRANT = 2'd2
    } arb_state_t;

    // Widest LFSR the step helper supports; callers zero-extend into this.
    localparam int LFSR_MAX_W = 32;

    localparam logic [7:0] DEF_TAPS = 8'h1D;
    localparam logic [7:0] DEF_SEED = 8'h01;

    localparam logic [LFSR_MAX_W-1:0] LFSR_ONE = {{(LFSR_MAX_W-1){1'b0}}, 1'b1};

    // One Galois shift of an nbits-wide LFSR. An all-zero result would lock
    // the generator, so the fallback seed is substituted.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps,
        input logic [LFSR_MAX_W-1:0] seed,
        input int                    nbits
    );
        logic [LFSR_MAX_W-1:0] mask;
        logic [LFSR_MAX_W-1:0] nxt;
        logic                  msb;
        if (nbits >= LFSR_MAX_W) begin
            mask = '1;
        end else begin
            mask = (LFSR_ONE << nbits) - LFSR_ONE;
        end
        msb = |(state & (LFSR_ONE << (nbits - 1)));
        nxt = ((state << 1) ^ (msb ? taps : '0)) & mask;
        if (nxt == '0) begin
            nxt = seed & mask;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lfsr_rng_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after rr_ptr,
// wrapping modulo NREQ.
module rr_pick
    import lfsr_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic             any_req,
    output logic [PTR_W-1:0] idx
);

    logic             found;
    int               cand;
    logic [PTR_W-1:0] cand_idx;

    // Scan from the pointer outward and keep the first hit.
    always_comb begin
        any_req  = |req;
        idx      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = PTR_W'(cand);
            if (!found && req[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/lfsr_rng_arbiter.sv
// Round-robin arbiter sharing one Galois LFSR among NREQ requesters.
// Each grant advances the LFSR STEPS times, then returns it on rnd_out.
// Build option: define LFSR_ARB_FREERUN_EN to also step the LFSR while
// waiting in IDLE and during GRANT (output then depends on request timing).
//
// state | meaning
// IDLE  | waiting; reseed or pick next requester round-robin
// STEP  | advancing LFSR, STEPS shifts; aborts if the requester drops req
// GRANT | one cycle; registers ack/rnd_out and moves the round-robin pointer
module lfsr_rng_arbiter
    import lfsr_arb_pkg::*;
#(
    parameter int               NREQ  = 4,
    parameter int               NBITS = 8,
    parameter logic [NBITS-1:0] TAPS  = NBITS'(DEF_TAPS),
    parameter logic [NBITS-1:0] SEED  = NBITS'(DEF_SEED),
    parameter int               STEPS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  ack,
    output logic [NBITS-1:0] rnd_out,
    output logic             busy,
    input  logic             reseed,
    input  logic [NBITS-1:0] seed_in
);

    localparam int         PTR_W     = $clog2(NREQ);
    localparam logic [7:0] LAST_STEP = 8'(STEPS - 1);

    arb_state_t       state;
    logic [NBITS-1:0] lfsr;
    logic [NBITS-1:0] lfsr_nxt;
    logic [7:0]       step_cnt;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] pick_idx;
    logic             any_req;

    assign lfsr_nxt = NBITS'(lfsr_next(LFSR_MAX_W'(lfsr), LFSR_MAX_W'(TAPS),
                                       LFSR_MAX_W'(SEED), NBITS));

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .any_req (any_req),
        .idx     (pick_idx)
    );

    // Arbitration FSM with the LFSR register and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            lfsr     <= SEED;
            ack      <= '0;
            rnd_out  <= '0;
            busy     <= 1'b0;
            step_cnt <= '0;
            rr_ptr   <= '0;
            gnt_idx  <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (reseed) begin
                        lfsr <= (seed_in == '0) ? SEED : seed_in;
                    end else if (any_req) begin
                        gnt_idx  <= pick_idx;
                        step_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= STEP;
                    end
`ifdef LFSR_ARB_FREERUN_EN
                    else begin
                        lfsr <= lfsr_nxt;
                    end
`endif
                end
                STEP: begin
                    // A requester that gives up mid-sequence forfeits its turn;
                    // the LFSR keeps whatever shifts already happened.
                    if (!req[gnt_idx]) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        lfsr     <= lfsr_nxt;
                        step_cnt <= step_cnt + 8'd1;
                        if (step_cnt == LAST_STEP) begin
                            state <= GRANT;
                        end
                    end
                end
                GRANT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (req[gnt_idx]) begin
                        ack[gnt_idx] <= 1'b1;
                        rnd_out      <= lfsr;
                        if (gnt_idx == PTR_W'(NREQ - 1)) begin
                            rr_ptr <= '0;
                        end else begin
                            rr_ptr <= gnt_idx + PTR_W'(1);
                        end
                    end
`ifdef LFSR_ARB_FREERUN_EN
                    lfsr <= lfsr_nxt;
`endif
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// Directed bench for lfsr_rng_arbiter: table of grant transactions plus
// hand sequences for abort, asynchronous reset and the free-run option.
module tb_lfsr_rng_arbiter;

    localparam int         NREQ  = 4;
    localparam int         NBITS = 8;
    localparam int         STEPS = 8;
    localparam logic [7:0] TAPS  = 8'h1D;
    localparam logic [7:0] SEED  = 8'h01;
    localparam int         LAT   = STEPS + 2;
    localparam int         BUSYN = STEPS + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  ack;
    logic [NBITS-1:0] rnd_out;
    logic             busy;
    logic             reseed;
    logic [NBITS-1:0] seed_in;

    int n_vec = 0;
    int n_err = 0;
    int multi_hot = 0;

    typedef struct {
        logic [3:0] req;
        logic       reseed;
        logic [7:0] seed;
        logic [3:0] exp_ack;
        logic [7:0] exp_rnd;
    } vec_t;

    vec_t       vt[12];
    int         nv = 0;
    logic [7:0] m;

    always #5 clk = ~clk;

    lfsr_rng_arbiter #(
        .NREQ  (NREQ),
        .NBITS (NBITS),
        .TAPS  (TAPS),
        .SEED  (SEED),
        .STEPS (STEPS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .ack     (ack),
        .rnd_out (rnd_out),
        .busy    (busy),
        .reseed  (reseed),
        .seed_in (seed_in)
    );

    always @(negedge clk) begin
        if (reset === 1'b1 && $countones(ack) > 1) multi_hot++;
    end

    function automatic logic [7:0] succ(input logic [7:0] s, input int n);
        logic [7:0] v;
        v = s;
        for (int i = 0; i < n; i++) begin
            v = {v[6:0], 1'b0} ^ (v[7] ? TAPS : 8'h00);
            if (v == 8'h00) v = SEED;
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] r, input logic rs, input logic [7:0] sd,
                       input logic [3:0] ea);
        if (rs) m = (sd == 8'h00) ? SEED : sd;
        m = succ(m, STEPS);
        vt[nv] = '{req: r, reseed: rs, seed: sd, exp_ack: ea, exp_rnd: m};
        nv++;
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge where ack is seen.
    task automatic wait_grant(output logic [3:0] got, output int cycles, output int busy_cyc);
        got = '0;
        cycles = 0;
        busy_cyc = 0;
        while (got == '0 && cycles < 40) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (busy) busy_cyc++;
            got = ack;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] got;
        int         cyc;
        int         bcyc;
        logic [3:0] seen;

        m = SEED;
        add(4'b0001, 1'b0, 8'h00, 4'b0001);
        add(4'b1111, 1'b0, 8'h00, 4'b0010);
        add(4'b1111, 1'b0, 8'h00, 4'b0100);
        add(4'b1111, 1'b0, 8'h00, 4'b1000);
        add(4'b1111, 1'b0, 8'h00, 4'b0001);
        add(4'b1111, 1'b0, 8'h00, 4'b0010);
        add(4'b0100, 1'b1, 8'h00, 4'b0100);
        add(4'b1000, 1'b1, 8'hA5, 4'b1000);
        add(4'b0110, 1'b0, 8'h00, 4'b0010);
        add(4'b0011, 1'b0, 8'h00, 4'b0001);
        add(4'b1100, 1'b0, 8'h00, 4'b0100);
        add(4'b0101, 1'b0, 8'h00, 4'b0001);

        reset = 1'b0;
        req = '0;
        reseed = 1'b0;
        seed_in = '0;
        repeat (2) @(negedge clk);
        check("reset_ack", 32'(ack), 32'h0);
        check("reset_rnd", 32'(rnd_out), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < nv; i++) begin
            if (vt[i].reseed) begin
                req = '0;
                reseed = 1'b1;
                seed_in = vt[i].seed;
                @(negedge clk);
                reseed = 1'b0;
            end
            req = vt[i].req;
            wait_grant(got, cyc, bcyc);
            check($sformatf("vec%0d_ack", i), 32'(got), 32'(vt[i].exp_ack));
            check($sformatf("vec%0d_latency", i), 32'(cyc), 32'(LAT));
            check($sformatf("vec%0d_busy_cycles", i), 32'(bcyc), 32'(BUSYN));
`ifndef LFSR_ARB_FREERUN_EN
            check($sformatf("vec%0d_rnd", i), 32'(rnd_out), 32'(vt[i].exp_rnd));
`endif
        end

        // rnd_out holds and ack stays low with no requests
        req = '0;
        seen = '0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | ack;
        end
        check("idle_no_ack", 32'(seen), 32'h0);
`ifndef LFSR_ARB_FREERUN_EN
        check("rnd_held", 32'(rnd_out), 32'(vt[nv-1].exp_rnd));
`endif

        // requester 2 drops mid-STEP: no grant, pointer must stay put
        req = 4'b0100;
        repeat (4) @(negedge clk);
        check("abort_busy_in_step", 32'(busy), 32'h1);
        req = '0;
        seen = '0;
        repeat (15) begin
            @(negedge clk);
            seen = seen | ack;
        end
        check("abort_no_ack", 32'(seen), 32'h0);
        check("abort_busy_low", 32'(busy), 32'h0);
        req = 4'b0101;
        wait_grant(got, cyc, bcyc);
        check("after_abort_ack", 32'(got), 32'h4);
        check("after_abort_latency", 32'(cyc), 32'(LAT));

        // asynchronous reset in the middle of STEP
        req = 4'b0001;
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_rst_ack", 32'(ack), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_rnd", 32'(rnd_out), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        wait_grant(got, cyc, bcyc);
        check("post_rst_ack", 32'(got), 32'h1);
        check("post_rst_latency", 32'(cyc), 32'(LAT));
        check("post_rst_rnd", 32'(rnd_out), 32'(succ(SEED, STEPS)));

        // five idle cycles after reset, then a request from requester 0
        req = '0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        req = 4'b0001;
        wait_grant(got, cyc, bcyc);
        check("idle5_ack", 32'(got), 32'h1);
`ifdef LFSR_ARB_FREERUN_EN
        check("idle5_rnd", 32'(rnd_out), 32'(succ(SEED, STEPS + 5)));
`else
        check("idle5_rnd", 32'(rnd_out), 32'(succ(SEED, STEPS)));
`endif
        req = '0;
        @(negedge clk);

        check("ack_one_hot", 32'(multi_hot), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
